// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port between N_REQ
//            producers. It keeps a conservative local occupancy count so that
//            a full FIFO is never written, and it allows bounded bursts
//            (up to MAX_BURST back-to-back grants) per owner. The winning
//            write is registered onto fifo_wr_en_o / fifo_wr_data_o.
// Ports    :
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   req_i          - per-requester write request, held until granted
//   req_data_i     - per-requester data, slice i = [i*WIDTH +: WIDTH]
//   gnt_o          - combinational one-hot (or zero) grant
//   fifo_wr_en_o   - registered FIFO write strobe
//   fifo_wr_data_o - registered FIFO write data
//   fifo_rd_en_i   - tap of the FIFO read enable
//   fifo_empty_i   - FIFO empty flag
//   fifo_full_i    - FIFO full flag (error detection only)
//   level_o        - local occupancy count incl. the in-flight write
//   owner_o        - index of the last granted requester
//   ovf_err_o      - sticky write-while-full error
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_BURST = 2,
  localparam int OWN_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   fifo_wr_en_o,
  output logic [WIDTH-1:0]       fifo_wr_data_o,
  input  logic                   fifo_rd_en_i,
  input  logic                   fifo_empty_i,
  input  logic                   fifo_full_i,
  output logic [CNT_W-1:0]       level_o,
  output logic [OWN_W-1:0]       owner_o,
  output logic                   ovf_err_o
);

  localparam int                 BC_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
  localparam logic [BC_W-1:0]    MAX_BC  = BC_W'(MAX_BURST);
  localparam logic [OWN_W:0]     NREQ_C  = (OWN_W+1)'(N_REQ);
  localparam logic [OWN_W-1:0]   OWN_RST = OWN_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic               wr_en_q;
  logic [WIDTH-1:0]   wr_data_q;
  logic               ovf_q;

  logic               space;
  logic               cont;
  logic               rr_found;
  logic [OWN_W-1:0]   rr_idx;
  logic [OWN_W:0]     rr_sum;
  logic               grant;
  logic [OWN_W-1:0]   gidx;
  logic               push;
  logic               pop;

  // A same-cycle pop is deliberately not credited here: the count stays
  // conservative and gnt_o never depends on the FIFO flags.
  assign space = (level_q < DEPTH_C);

  // Current owner may keep the port while it still requests and its burst
  // budget is not used up.
  assign cont = (state_q == S_BURST) && req_i[owner_q] && (bcnt_q < MAX_BC);

  // Round-robin search starting at owner+1; iterating from the far end
  // lets the nearest requester overwrite the result, so the owner itself
  // (offset N_REQ) is searched last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_sum = {1'b0, owner_q} + (OWN_W+1)'(k);
      if (rr_sum >= NREQ_C) begin
        rr_sum = rr_sum - NREQ_C;
      end
      if (req_i[rr_sum[OWN_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[OWN_W-1:0];
      end
    end
  end

  // A continuing owner that lacks space stalls: nobody else may preempt it.
  always_comb begin
    if (cont) begin
      grant = space;
      gidx  = owner_q;
    end else begin
      grant = rr_found & space;
      gidx  = rr_idx;
    end
    // Keep the grant low while reset is asserted.
    grant = grant & rst_n;
  end

  assign gnt_o = grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << gidx) : '0;

  assign push = grant;
  assign pop  = fifo_rd_en_i & ~fifo_empty_i & (level_q != '0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    if (grant) begin
      state_d = S_BURST;
      owner_d = gidx;
      bcnt_d  = cont ? (bcnt_q + BC_W'(1)) : BC_W'(1);
    end else if (req_i == '0) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + CNT_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_RST;
      bcnt_q    <= '0;
      level_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      level_q <= level_d;
      wr_en_q <= grant;
      if (grant) begin
        wr_data_q <= req_data_i[gidx*WIDTH +: WIDTH];
      end
      ovf_q <= ovf_q | (wr_en_q & fifo_full_i);
    end
  end

  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_wr_data_o = wr_data_q;
  assign level_o        = level_q;
  assign owner_o        = owner_q;
  assign ovf_err_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter with a small
//            behavioural 8-deep FIFO model on the write/read side.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [WIDTH-1:0]       d [0:N_REQ-1];
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic                   wr_en;
  logic [WIDTH-1:0]       wr_data;
  logic                   rd;
  logic                   f_empty;
  logic                   f_full;
  logic [3:0]             level;
  logic [1:0]             owner;
  logic                   ovf;

  int n_asrt = 0;
  int n_fail = 0;

  // External FIFO model: occupancy and a log of written words.
  int               fcnt;
  int               wr_n;
  logic [WIDTH-1:0] wlog [0:15];

  assign req_data = {d[3], d[2], d[1], d[0]};
  assign f_empty  = (fcnt == 0);
  assign f_full   = (fcnt == 8);

  fifo_wr_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .req_data_i     (req_data),
    .gnt_o          (gnt),
    .fifo_wr_en_o   (wr_en),
    .fifo_wr_data_o (wr_data),
    .fifo_rd_en_i   (rd),
    .fifo_empty_i   (f_empty),
    .fifo_full_i    (f_full),
    .level_o        (level),
    .owner_o        (owner),
    .ovf_err_o      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 0;
      wr_n <= 0;
    end else begin
      fcnt <= fcnt + ((wr_en && fcnt != 8) ? 1 : 0) - ((rd && fcnt != 0) ? 1 : 0);
      if (wr_en && fcnt != 8) begin
        if (wr_n < 16) wlog[wr_n] <= wr_data;
        wr_n <= wr_n + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req   = '0;
    rd    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  initial begin
    int exp_rot [9];
    int ng;
    logic [N_REQ-1:0] g;
    exp_rot = '{1, 1, 2, 2, 4, 4, 8, 8, 1};

    rst_n = 1'b0;
    req   = '0;
    rd    = 1'b0;
    for (int i = 0; i < N_REQ; i++) d[i] = WIDTH'(8'hA0 + i);

    // ---------------- Reset ----------------
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_wr_en", 32'(wr_en), 0);
    check_eq("rst_owner", 32'(owner), 3);
    check_eq("rst_ovf",   32'(ovf),   0);
    req = 4'b1111;
    #1;
    check_eq("rst_gnt_held", 32'(gnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_gnt", 32'(gnt), 1);
    @(posedge clk); #1;
    check_eq("lat_wr_en",   32'(wr_en),   1);
    check_eq("lat_wr_data", 32'(wr_data), 32'h A0);
    check_eq("lat_level",   32'(level),   1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_wr_en",   32'(wr_en),   0);
    check_eq("midrst_wr_data", 32'(wr_data), 0);
    check_eq("midrst_level",   32'(level),   0);
    check_eq("midrst_gnt",     32'(gnt),     0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("postrst_gnt", 32'(gnt), 1);

    // ---------------- Fair burst rotation ----------------
    rd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq($sformatf("rot_gnt%0d", i), 32'(gnt), 32'(exp_rot[i]));
      check_eq($sformatf("rot_lvl%0d", i), 32'(level <= 4'd2), 1);
      @(posedge clk); #1;
    end
    req = '0;
    for (int i = 0; i < 20 && level != 0; i++) begin
      @(posedge clk); #1;
    end
    check_eq("drain_level", 32'(level), 0);
    rd = 1'b0;

    // ---------------- Fill to full ----------------
    apply_reset();
    req  = 4'b0001;
    d[0] = 8'h01;
    ng   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = gnt;
      if (g[0]) ng++;
      @(posedge clk); #1;
      if (g[0]) d[0] = d[0] + 8'h01;
    end
    check_eq("fill_ngrants", 32'(ng),     8);
    check_eq("fill_level",   32'(level),  8);
    check_eq("fill_gnt",     32'(gnt),    0);
    check_eq("fill_full",    32'(f_full), 1);
    check_eq("fill_wr_en",   32'(wr_en),  0);
    check_eq("fill_ovf",     32'(ovf),    0);
    check_eq("fill_nwrites", 32'(wr_n),   8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("fill_data%0d", i), 32'(wlog[i]), 32'(i + 1));
    end

    // ---------------- Simultaneous push/pop ----------------
    rd = 1'b1;
    @(negedge clk);
    check_eq("pp_full_nogrant", 32'(gnt), 0);
    @(posedge clk); #1;
    check_eq("pp_pop_level", 32'(level), 7);
    @(negedge clk);
    check_eq("pp_grant_after_pop", 32'(gnt), 1);
    @(posedge clk); #1;
    check_eq("pp_both_level", 32'(level), 7);
    rd = 1'b0;
    @(negedge clk);
    check_eq("pp_grant2", 32'(gnt), 1);
    @(posedge clk); #1;
    check_eq("pp_push_level", 32'(level), 8);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pp_ovf", 32'(ovf), 0);

    // ---------------- Early rotation ----------------
    apply_reset();
    d[1] = 8'h11;
    d[2] = 8'h22;
    req  = 4'b0010;
    @(negedge clk);
    check_eq("er_gnt1", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    check_eq("er_owner1", 32'(owner),   1);
    check_eq("er_data1",  32'(wr_data), 32'h11);
    req = 4'b0100;
    @(negedge clk);
    check_eq("er_gnt2", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    check_eq("er_owner2", 32'(owner),   2);
    check_eq("er_wr_en2", 32'(wr_en),   1);
    check_eq("er_data2",  32'(wr_data), 32'h22);
    req = '0;
    @(negedge clk);
    check_eq("er_gnt_none", 32'(gnt), 0);
    @(posedge clk); #1;
    check_eq("er_wr_en_drop", 32'(wr_en), 0);

    // ---------------- Stall ----------------
    apply_reset();
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_eq($sformatf("st_fill%0d", i), 32'(gnt), 1);
      @(posedge clk);
    end
    #1;
    req = 4'b1000;
    @(negedge clk);
    check_eq("st_gnt3", 32'(gnt), 32'h8);
    @(posedge clk); #1;
    check_eq("st_owner3", 32'(owner), 3);
    check_eq("st_level8", 32'(level), 8);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("st_stall%0d", i), 32'(gnt), 0);
    end
    @(posedge clk); #1;
    rd = 1'b1;
    @(negedge clk);
    check_eq("st_pop_cycle_gnt", 32'(gnt), 0);
    @(posedge clk); #1;
    rd = 1'b0;
    check_eq("st_level7", 32'(level), 7);
    @(negedge clk);
    check_eq("st_regrant3", 32'(gnt), 32'h8);
    @(posedge clk); #1;
    check_eq("st_level8b", 32'(level), 8);
    @(negedge clk);
    check_eq("st_rot_blocked", 32'(gnt), 0);
    @(posedge clk); #1;
    rd = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rd = 1'b0;
    check_eq("st_level7b", 32'(level), 7);
    @(negedge clk);
    check_eq("st_rot_to0", 32'(gnt), 1);
    @(posedge clk); #1;
    check_eq("st_owner0", 32'(owner), 0);
    check_eq("st_ovf",    32'(ovf),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one 8-bit × 8-deep `fifo` write port between `N_REQ` producers. It keeps a conservative local occupancy count, so no write is ever issued to a full FIFO. It supports bounded bursts per owner, and it registers the winning write onto `fifo_wr_en` and `fifo_wr_data`. It sits directly in front of `fifo` and taps the FIFO read side to track drains.

## Interface
- `N_REQ`, 4, number of requesters.
- `WIDTH`, 8, data width; matches the FIFO data width.
- `DEPTH`, 8, FIFO depth in entries.
- `CNT_W`, 4, occupancy counter width; equals clog2(`DEPTH`)+1.
- `MAX_BURST`, 2, maximum consecutive grants to one owner before rotation; must be ≥1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester write request; held until granted.
- `req_data`  in  N_REQ*WIDTH  per-requester data; slice i is bits [i*WIDTH +: WIDTH].
- `gnt`  out  N_REQ  combinational, one-hot or zero; gnt[i]=1 means slice i is taken at this edge.
- `fifo_wr_en`  out  1  registered write strobe to the FIFO.
- `fifo_wr_data`  out  WIDTH  registered write data to the FIFO.
- `fifo_rd_en`  in  1  tap of the FIFO read enable.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_full`  in  1  FIFO full flag; used only for error detection.
- `level`  out  CNT_W  local occupancy count, 0..`DEPTH`, including the in-flight write.
- `owner`  out  clog2(N_REQ)  index of the last granted requester.
- `ovf_err`  out  1  sticky; clears only on reset.

## Operation
- FSM has two states.
  - IDLE: no current owner.
  - BURST: `owner` holds the grant; `bcnt` counts grants in the current burst (1..`MAX_BURST`).
- Space condition: `space = (level < DEPTH)`. A pop in the same cycle is ignored when computing `space`, which keeps the count conservative.
- Arbitration, in IDLE or at rotation: search `req` starting at index `owner+1` and wrapping modulo `N_REQ`. The current owner is searched last. The first requester found is granted if `space` is true.
- BURST continuation:
  - Grant `owner` again when `req[owner]` is high, `space` is true and `bcnt < MAX_BURST`; then `bcnt` increments.
  - Rotate (run arbitration) when `req[owner]` is low or `bcnt == MAX_BURST`.
- Stall: in BURST with `req[owner]` high, `bcnt < MAX_BURST` and `space` false:
  - no grant;
  - state and `bcnt` hold;
  - other requesters do not preempt the owner.
- When a grant is issued to requester i: `owner` becomes i; state becomes BURST; `bcnt` is 1 on a new owner and increments on a continuation.
- No grant and no pending `req`: state goes to IDLE and `owner` is retained.
- Occupancy count:
  - `push` = any `gnt` bit high.
  - `pop` = `fifo_rd_en & ~fifo_empty`.
  - `level` changes by +1 (push only), −1 (pop only) or 0 (both or neither).
  - `level` never wraps; the arbiter never pushes at `DEPTH`, and `pop` at `level == 0` is ignored.
- Error detection: `ovf_err` sets at any edge where `fifo_wr_en & fifo_full`. This must never happen in correct operation.
- `gnt` depends only on `req`, `state`, `owner`, `bcnt` and `level`. It has no combinational path from the FIFO flags.

## Timing
- Reset (`rst_n` low, asynchronous), values take effect immediately:
  - `gnt`=0, `fifo_wr_en`=0, `fifo_wr_data`=0, `level`=0, `ovf_err`=0.
  - State IDLE, `bcnt`=0, `owner`=`N_REQ`-1, so requester 0 has first priority.
- Handshake: `req[i]` and its data slice stay stable until the rising edge where `gnt[i]`=1. At that edge the data is consumed. The requester may update `req` and data after that edge.
- Latency: grant at edge k sets `fifo_wr_en`=1 during cycle k→k+1, with the granted data on `fifo_wr_data`. The FIFO writes at edge k+1. `level` increments at edge k.
- Throughput: one write per cycle, sustained, while `space` holds.
- `fifo_wr_en` drops to 0 in the cycle after a no-grant edge.
- Reset asserted mid-burst: the pending write is dropped and all state clears. The first grant after release goes to the lowest-index active requester.

## Test plan
- **Reset:** drive `rst_n`=0 between edges with `fifo_wr_en`=1 → all outputs go to 0 immediately. After release, with `req`=4'b1111, the first grant is `gnt`=4'b0001.
- **Fair burst rotation:** `req`=4'b1111 held continuously, FIFO read every cycle, `MAX_BURST`=2 → grant order 0,0,1,1,2,2,3,3,0. `level` stays ≤2.
- **Fill to full:** only `req[0]`, data 0x01..0x0A, no reads → exactly 8 grants, data 0x01..0x08 written, `level`=8, `gnt`=0 thereafter, `fifo_full`=1, `ovf_err`=0.
- **Simultaneous push/pop:** at `level`=7, grant plus `fifo_rd_en`=1 with `fifo_empty`=0 → `level` stays 7. At `level`=8, pop only → `level`=7, and the next cycle grants.
- **Early rotation:** `req[1]` high for one grant then low, `req[2]` high → `gnt[2]` on the very next cycle with no idle cycle, `owner`=2.
- **Stall:** owner 3 with `bcnt`=1, `level`=8, `req`=4'b1001 → no grants while full. After one pop, `gnt[3]` is granted, then rotation to requester 0.
